seq_stream_gen: RTL and testbench

- Serial bitstream generator: the transmit-side counterpart of the sequence detector.
- Accepts a pattern word, a bit length and a repeat count through a valid/ready start handshake.
- Emits the pattern MSB-first, one bit per clock, on a single-bit stream that feeds the detector's input.
- Used in system tests and in-system self-test of the detector path.

---
 rtl/seq_stream_pkg.sv | 27 ++
 rtl/seq_stream_shifter.sv | 51 +++++
 rtl/seq_stream_gen.sv | 176 +++++++++++++++++
 tb/tb_seq_stream_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_stream_pkg.sv
// Shared definitions for the serial stream generator and its detector bench.
// Optional feature macro: SEQ_STREAM_GEN_PARITY_EN (adds the PARITY state).
package seq_stream_pkg;

  localparam int unsigned DefPatW = 8;
  localparam int unsigned DefCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
`ifdef SEQ_STREAM_GEN_PARITY_EN
    StParity,
`endif
    StDone
  } state_e;

  // Length 0 or anything wider than the pattern register means "full width".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_w);
    return ((len == 0) || (len > max_w)) ? max_w : len;
  endfunction

  // A repeat count of 0 still sends the pattern once.
  function automatic int unsigned eff_rep(input int unsigned rep);
    return (rep == 0) ? 32'd1 : rep;
  endfunction

endpackage

// File: rtl/seq_stream_shifter.sv
// Pattern register with MSB-first bit index; the FSM drives load/reload/step/clear.
module seq_stream_shifter #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             step,
  input  logic             clear,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             bit_out,
  output logic             parity,
  output logic             last
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [PAT_W-1:0] mask;

  // Bits above the effective length are dropped at load so parity needs no mask later.
  assign mask    = ~({PAT_W{1'b1}} << len_in);
  assign bit_out = |(pat_q & (PAT_W'(1) << idx_q));
  assign parity  = ^pat_q;
  assign last    = (idx_q == '0);

  // Pattern, length and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      pat_q <= pat_in & mask;
      len_q <= len_in;
      idx_q <= len_in - LEN_W'(1);
    end else if (reload) begin
      idx_q <= len_q - LEN_W'(1);
    end else if (step) begin
      idx_q <= idx_q - LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_stream_gen.sv
// Serial bitstream generator: emits a latched pattern MSB-first, repeated rep_cnt times.
// Optional feature macro: SEQ_STREAM_GEN_PARITY_EN appends an even-parity bit per repetition.
module seq_stream_gen
  import seq_stream_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             out_stream,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             stream_q, stream_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             sh_load, sh_reload, sh_step, sh_clear;
  logic             sh_bit, sh_parity, sh_last;
  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] rep_extra;

  assign len_eff   = LEN_W'(eff_len(32'(pat_len), PAT_W));
  // rep_q counts repetitions still to come after the current one.
  assign rep_extra = CNT_W'(eff_rep(32'(rep_cnt)) - 32'd1);

  assign out_stream  = stream_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_ready = ready_q;

  seq_stream_shifter #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (sh_load),
    .reload (sh_reload),
    .step   (sh_step),
    .clear  (sh_clear),
    .pat_in (pat_in),
    .len_in (len_eff),
    .bit_out(sh_bit),
    .parity (sh_parity),
    .last   (sh_last)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    stream_d  = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ready_d   = ready_q;
    sh_load   = 1'b0;
    sh_reload = 1'b0;
    sh_step   = 1'b0;
    sh_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start_valid && ready_q) begin
          sh_load = 1'b1;
          rep_d   = rep_extra;
          state_d = StShift;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StShift: begin
        if (abort) begin
          sh_clear = 1'b1;
          state_d  = StIdle;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end else begin
          valid_d  = 1'b1;
          stream_d = sh_bit;
          if (sh_last) begin
`ifdef SEQ_STREAM_GEN_PARITY_EN
            state_d = StParity;
`else
            if (rep_q != '0) begin
              rep_d     = rep_q - CNT_W'(1);
              sh_reload = 1'b1;
            end else begin
              state_d = StDone;
            end
`endif
          end else begin
            sh_step = 1'b1;
          end
        end
      end
`ifdef SEQ_STREAM_GEN_PARITY_EN
      StParity: begin
        if (abort) begin
          sh_clear = 1'b1;
          state_d  = StIdle;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end else begin
          valid_d  = 1'b1;
          stream_d = sh_parity;
          if (rep_q != '0) begin
            rep_d     = rep_q - CNT_W'(1);
            sh_reload = 1'b1;
            state_d   = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
`endif
      StDone: begin
        // Abort is not sampled here: the transmission already finished.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, repeat counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rep_q    <= '0;
      stream_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      stream_q <= stream_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Reference sh_parity in the default build so it is not left dangling.
`ifndef SEQ_STREAM_GEN_PARITY_EN
  logic unused_parity;
  assign unused_parity = sh_parity;
`endif

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed bench for seq_stream_gen; follows SEQ_STREAM_GEN_PARITY_EN for expected streams.
module tb_seq_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pat_in;
  logic [3:0] pat_len;
  logic [7:0] rep_cnt;
  logic       start_valid;
  logic       start_ready;
  logic       abort;
  logic       out_stream;
  logic       out_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [7:0]  rep;
    logic [31:0] bits;  // expected stream, right-aligned, first bit at position n-1
    int          n;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_stream_gen #(
    .PAT_W(8),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .pat_in     (pat_in),
    .pat_len    (pat_len),
    .rep_cnt    (rep_cnt),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort      (abort),
    .out_stream (out_stream),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after the handshake edge; consumes n bit cycles plus the done cycle.
  task automatic expect_stream(input logic [31:0] bits, input int n, input string tag);
    logic [31:0] sh;
    for (int i = 0; i < n; i++) begin
      tick();
      sh = bits >> (n - 1 - i);
      chk1({tag, " out_valid"}, out_valid, 1'b1);
      chk1({tag, " out_stream"}, out_stream, sh[0]);
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " done early"}, done, 1'b0);
    end
    tick();
    chk1({tag, " done pulse"}, done, 1'b1);
    chk1({tag, " valid after"}, out_valid, 1'b0);
    chk1({tag, " stream after"}, out_stream, 1'b0);
    chk1({tag, " ready at done"}, start_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    pat_in      = v.pat;
    pat_len     = v.len;
    rep_cnt     = v.rep;
    start_valid = 1'b1;
    chk1({tag, " ready idle"}, start_ready, 1'b1);
    tick();
    start_valid = 1'b0;
    chk1({tag, " ready taken"}, start_ready, 1'b0);
    chk1({tag, " busy taken"}, busy, 1'b1);
    chk1({tag, " valid gap"}, out_valid, 1'b0);
    expect_stream(v.bits, v.n, tag);
    tick();
    chk1({tag, " done once"}, done, 1'b0);
    chk1({tag, " busy idle"}, busy, 1'b0);
    chk1({tag, " ready back"}, start_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] bits_a, bits_b;
    int          n_a, n_b;
`ifdef SEQ_STREAM_GEN_PARITY_EN
    vecs[0] = '{8'h09, 4'd4,  8'd3, 32'b10010_10010_10010, 15};
    vecs[1] = '{8'hA5, 4'd0,  8'd0, 32'b10100101_0, 9};
    vecs[2] = '{8'h0B, 4'd4,  8'd2, 32'b10111_10111, 10};
    vecs[3] = '{8'h80, 4'd8,  8'd1, 32'b10000000_1, 9};
    vecs[4] = '{8'hFE, 4'd2,  8'd3, 32'b101_101_101, 9};
    vecs[5] = '{8'h01, 4'd1,  8'd5, 32'b11_11_11_11_11, 10};
    vecs[6] = '{8'h3C, 4'd15, 8'd1, 32'b00111100_0, 9};
    bits_a = 32'b10111;  n_a = 5;  // 0B, len 4, once
    bits_b = 32'b10010;  n_b = 5;  // 09, len 4, once
`else
    vecs[0] = '{8'h09, 4'd4,  8'd3, 32'b1001_1001_1001, 12};
    vecs[1] = '{8'hA5, 4'd0,  8'd0, 32'b10100101, 8};
    vecs[2] = '{8'h0B, 4'd4,  8'd2, 32'b1011_1011, 8};
    vecs[3] = '{8'h80, 4'd8,  8'd1, 32'b10000000, 8};
    vecs[4] = '{8'hFE, 4'd2,  8'd3, 32'b10_10_10, 6};
    vecs[5] = '{8'h01, 4'd1,  8'd5, 32'b11111, 5};
    vecs[6] = '{8'h3C, 4'd15, 8'd1, 32'b00111100, 8};
    bits_a = 32'b1011;  n_a = 4;
    bits_b = 32'b1001;  n_b = 4;
`endif

    rst_n       = 1'b0;
    pat_in      = '0;
    pat_len     = '0;
    rep_cnt     = '0;
    start_valid = 1'b0;
    abort       = 1'b0;

    @(negedge clk);
    chk1("reset start_ready", start_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset out_stream", out_stream, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // Abort on the 5th valid bit, then a new request straight away.
    pat_in      = 8'hFF;
    pat_len     = 4'd8;
    rep_cnt     = 8'd2;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("abort pre bit", out_stream, 1'b1);
      chk1("abort pre valid", out_valid, 1'b1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort valid", out_valid, 1'b0);
    chk1("abort stream", out_stream, 1'b0);
    chk1("abort busy", busy, 1'b0);
    chk1("abort ready", start_ready, 1'b1);
    chk1("abort no done", done, 1'b0);
    run_vec(vecs[2], "post_abort");

    // Asynchronous reset between clock edges in the middle of a run.
    pat_in      = 8'h09;
    pat_len     = 4'd4;
    rep_cnt     = 8'd2;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk1("pre reset valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async rst valid", out_valid, 1'b0);
    chk1("async rst stream", out_stream, 1'b0);
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst done", done, 1'b0);
    chk1("async rst ready", start_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{8'h09, 4'd4, 8'd1, bits_b, n_b}, "post_reset");

    // start_valid held high through a whole transmission.
    pat_in      = 8'h0B;
    pat_len     = 4'd4;
    rep_cnt     = 8'd1;
    start_valid = 1'b1;
    tick();
    pat_in = 8'h09;
    expect_stream(bits_a, n_a, "held_a");
    tick();
    chk1("held second accept busy", busy, 1'b1);
    chk1("held second ready", start_ready, 1'b0);
    chk1("held gap valid", out_valid, 1'b0);
    chk1("held gap done", done, 1'b0);
    start_valid = 1'b0;
    expect_stream(bits_b, n_b, "held_b");
    tick();
    chk1("held end done", done, 1'b0);
    chk1("held end ready", start_ready, 1'b1);
    chk1("held end valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
